mips_control_fsm: RTL and testbench
===================================

# mips_control_fsm

Multi-cycle control unit for the MIPS teaching datapath: the producer side of the datapath control bus (reg_write_en, reg_dst, alu_src, alu_ctrl, mem_write_en, mem_to_reg). It sequences each instruction through fetch/decode/execute/memory/writeback states from the opcode and funct fields held in the datapath's instruction register. It also drives the PC, IR and memory-address-select controls that a shared-memory multi-cycle datapath needs. Outputs are Moore decodes of the state register; the only exception is pc_en, which also depends on the ALU zero flag.

## Interface
Parameters:
- none. Encodings are fixed by the ISA subset.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- opcode  input  6  instr[31:26] from the instruction register; valid from DECODE onward
- funct  input  6  instr[5:0]; valid from DECODE onward
- zero  input  1  ALU zero flag, combinational from the datapath
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  output  1  load instruction register
- mem_write_en  output  1  memory write strobe
- mem_to_reg  output  1  writeback select: 0 = ALUOut, 1 = memory data register
- reg_dst  output  1  destination select: 0 = rt, 1 = rd
- reg_write_en  output  1  register file write
- alu_src  output  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  output  2  ALU B select: 00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- alu_ctrl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_en  output  1  PC load = pc_write | (branch & zero)
- illegal_op  output  1  one-cycle pulse in DECODE on an unsupported opcode or funct
- instr_count  output  32  count of retired instructions
- state  output  4  current state, for debug and the bench

## Operation
- Supported opcodes: R-type 0x00 (funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt), lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11. Codes 12-15 are unreachable and go to FETCH.
- Unasserted outputs in every state are 0, except alu_ctrl, which defaults to 010.
- Per-state outputs and next state:
  - FETCH: iord=0, ir_write=1, alu_src=0, alu_src_b=01, alu_ctrl=010, pc_src=00, pc_write=1. Next: DECODE.
  - DECODE: alu_src=0, alu_src_b=11, alu_ctrl=010 (branch target into ALUOut).
    - lw, sw → MEMADR; R-type with legal funct → EXECUTE; beq → BRANCH; addi → ADDIEXEC; j → JUMP.
    - Anything else → FETCH with illegal_op=1; the instruction is not counted.
  - MEMADR: alu_src=1, alu_src_b=10, alu_ctrl=010. Next: lw → MEMRD, sw → MEMWR.
  - MEMRD: iord=1. Next: MEMWB.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write_en=1. Next: FETCH.
  - MEMWR: iord=1, mem_write_en=1. Next: FETCH.
  - EXECUTE: alu_src=1, alu_src_b=00, alu_ctrl decoded from funct. Next: ALUWB.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write_en=1. Next: FETCH.
  - BRANCH: alu_src=1, alu_src_b=00, alu_ctrl=110, pc_src=01, branch=1. Next: FETCH.
  - ADDIEXEC: alu_src=1, alu_src_b=10, alu_ctrl=010. Next: ADDIWB.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write_en=1. Next: FETCH.
  - JUMP: pc_src=10, pc_write=1. Next: FETCH.
- pc_write and branch are internal; only pc_en leaves the block.
- instr_count increments by 1 on the clock edge that leaves MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP. It wraps from 0xFFFF_FFFF to 0 silently.

## Timing
- Cycles per instruction (FETCH to return to FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- All outputs except pc_en are functions of the state register only. They are stable one clock-to-q after the edge.
- pc_en in BRANCH follows zero combinationally within the same cycle.
- opcode and funct are sampled combinationally in DECODE, EXECUTE and MEMADR. The IR changes only while ir_write=1, i.e. in FETCH.
- Reset:
  - rst_n low forces state=FETCH immediately (asynchronous) and clears instr_count to 0.
  - While in reset, the outputs take their FETCH values: ir_write=1, pc_en=1, alu_src_b=01, alu_ctrl=010, all others 0, illegal_op=0.
  - The datapath is held in reset by the same rst_n, so these values are harmless.
- Reset asserted mid-instruction: the current instruction is abandoned with no partial write after the reset edge. On the first rising edge after release, state goes FETCH → DECODE.

## Test plan
- Reset: hold rst_n=0 across 3 edges, then release → state=0, instr_count=0, ir_write=1, reg_write_en=0, mem_write_en=0. After one edge, state=1.
- lw (opcode 0x23): states 0,1,2,3,4,0 across 5 edges → iord=1 in MEMRD; reg_write_en=1 and mem_to_reg=1 only in MEMWB; instr_count=1.
- Back-to-back R-type: sub (funct 0x22), then slt (funct 0x2A) → alu_ctrl=110, then 111 in EXECUTE; reg_dst=1 in ALUWB; 8 cycles total; instr_count=2.
- beq:
  - With zero=1 in BRANCH → pc_en=1, pc_src=01.
  - Repeat with zero=0 → pc_en=0.
  - Both take 3 cycles.
- Illegal opcode 0x3F, then R-type funct 0x03 → illegal_op pulses for exactly one cycle in DECODE each time; state returns to 0; instr_count unchanged.
- Reset mid-sw: assert rst_n between clock edges during MEMADR → state=0 immediately, mem_write_en never asserted, instr_count=0.

Source files
------------

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS control unit: sequences each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath control bus.
module mips_control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        iord,
  output logic        ir_write,
  output logic        mem_write_en,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write_en,
  output logic        alu_src,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_ctrl,
  output logic [1:0]  pc_src,
  output logic        pc_en,
  output logic        illegal_op,
  output logic [31:0] instr_count,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t      state_q, state_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic        pc_write, branch, retire;
  logic        funct_legal;
  logic [2:0]  funct_alu;

  // NOTE: every variable driven here gets a default first, so no path
  // through the case statements can infer a latch.
  always_comb begin
    funct_legal = 1'b1;
    funct_alu   = ALU_ADD;
    case (funct)
      6'h20:   funct_alu = ALU_ADD;
      6'h22:   funct_alu = ALU_SUB;
      6'h24:   funct_alu = ALU_AND;
      6'h25:   funct_alu = ALU_OR;
      6'h2A:   funct_alu = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = S_FETCH;
    iord         = 1'b0;
    ir_write     = 1'b0;
    mem_write_en = 1'b0;
    mem_to_reg   = 1'b0;
    reg_dst      = 1'b0;
    reg_write_en = 1'b0;
    alu_src      = 1'b0;
    alu_src_b    = 2'b00;
    alu_ctrl     = ALU_ADD;
    pc_src       = 2'b00;
    pc_write     = 1'b0;
    branch       = 1'b0;
    illegal_op   = 1'b0;
    retire       = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          OP_RTYPE: begin
            if (funct_legal) state_d = S_EXECUTE;
            else             illegal_op = 1'b1;
          end
          default:      illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src   = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg   = 1'b1;
        reg_write_en = 1'b1;
        retire       = 1'b1;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        mem_write_en = 1'b1;
        retire       = 1'b1;
      end
      S_EXECUTE: begin
        alu_src  = 1'b1;
        alu_ctrl = funct_alu;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst      = 1'b1;
        reg_write_en = 1'b1;
        retire       = 1'b1;
      end
      S_BRANCH: begin
        alu_src  = 1'b1;
        alu_ctrl = ALU_SUB;
        pc_src   = 2'b01;
        branch   = 1'b1;
        retire   = 1'b1;
      end
      S_ADDIEXEC: begin
        alu_src   = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_en = 1'b1;
        retire       = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Every retiring state returns to FETCH, so counting on exit equals counting here.
  assign instr_count_d = retire ? instr_count_q + 32'd1 : instr_count_q;

  // NOTE: state registers use non-blocking assignments so all flops
  // update together on the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      instr_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign pc_en       = pc_write | (branch & zero);
  assign instr_count = instr_count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed bench for mips_control_fsm: walks each instruction class through
// its state sequence and compares control outputs against hand-derived values.
module tb_mips_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        zero;
  logic        iord, ir_write, mem_write_en, mem_to_reg, reg_dst, reg_write_en;
  logic        alu_src, pc_en, illegal_op;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_ctrl;
  logic [31:0] instr_count;
  logic [3:0]  state;

  int tests_run = 0;
  int tests_failed = 0;

  mips_control_fsm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .funct        (funct),
    .zero         (zero),
    .iord         (iord),
    .ir_write     (ir_write),
    .mem_write_en (mem_write_en),
    .mem_to_reg   (mem_to_reg),
    .reg_dst      (reg_dst),
    .reg_write_en (reg_write_en),
    .alu_src      (alu_src),
    .alu_src_b    (alu_src_b),
    .alu_ctrl     (alu_ctrl),
    .pc_src       (pc_src),
    .pc_en        (pc_en),
    .illegal_op   (illegal_op),
    .instr_count  (instr_count),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, sample on the following falling edge.
  task automatic step(input string tag, input logic [3:0] exp_state);
    @(posedge clk);
    @(negedge clk);
    check(tag, {28'd0, state}, {28'd0, exp_state});
  endtask

  task automatic run_rtype(input logic [5:0] fn, input logic [2:0] exp_alu, input logic [31:0] exp_cnt);
    opcode = 6'h00;
    funct  = fn;
    step("r_decode", 4'd1);
    check("r_decode_illegal", {31'd0, illegal_op}, 32'd0);
    step("r_execute", 4'd6);
    check("r_alu_ctrl", {29'd0, alu_ctrl}, {29'd0, exp_alu});
    check("r_alu_src", {31'd0, alu_src}, 32'd1);
    check("r_alu_src_b", {30'd0, alu_src_b}, 32'd0);
    step("r_aluwb", 4'd7);
    check("r_reg_dst", {31'd0, reg_dst}, 32'd1);
    check("r_reg_write", {31'd0, reg_write_en}, 32'd1);
    check("r_mem_to_reg", {31'd0, mem_to_reg}, 32'd0);
    step("r_fetch", 4'd0);
    check("r_count", instr_count, exp_cnt);
  endtask

  task automatic run_beq(input logic z, input logic [31:0] exp_cnt);
    opcode = 6'h04;
    funct  = 6'h00;
    zero   = z;
    step("beq_decode", 4'd1);
    check("beq_decode_src_b", {30'd0, alu_src_b}, 32'd3);
    check("beq_decode_pc_en", {31'd0, pc_en}, 32'd0);
    step("beq_branch", 4'd8);
    check("beq_pc_en", {31'd0, pc_en}, {31'd0, z});
    check("beq_pc_src", {30'd0, pc_src}, 32'd1);
    check("beq_alu_ctrl", {29'd0, alu_ctrl}, 32'd6);
    zero = ~z;
    #1;
    check("beq_pc_en_follows_zero", {31'd0, pc_en}, {31'd0, ~z});
    zero = z;
    step("beq_fetch", 4'd0);
    check("beq_count", instr_count, exp_cnt);
  endtask

  task automatic run_illegal(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] exp_cnt);
    opcode = op;
    funct  = fn;
    step("ill_decode", 4'd1);
    check("ill_pulse", {31'd0, illegal_op}, 32'd1);
    step("ill_fetch", 4'd0);
    check("ill_pulse_end", {31'd0, illegal_op}, 32'd0);
    check("ill_count", instr_count, exp_cnt);
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 6'h23;
    funct  = 6'h00;
    zero   = 1'b0;

    // Reset: outputs carry FETCH values while held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_pc_en", {31'd0, pc_en}, 32'd1);
    check("rst_alu_src_b", {30'd0, alu_src_b}, 32'd1);
    check("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd2);
    check("rst_illegal", {31'd0, illegal_op}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_state", {28'd0, state}, 32'd0);
    check("rel_count", instr_count, 32'd0);
    check("rel_ir_write", {31'd0, ir_write}, 32'd1);
    check("rel_reg_write", {31'd0, reg_write_en}, 32'd0);
    check("rel_mem_write", {31'd0, mem_write_en}, 32'd0);

    // lw: 0,1,2,3,4,0
    step("lw_decode", 4'd1);
    step("lw_memadr", 4'd2);
    check("lw_alu_src_b", {30'd0, alu_src_b}, 32'd2);
    check("lw_memadr_iord", {31'd0, iord}, 32'd0);
    step("lw_memrd", 4'd3);
    check("lw_iord", {31'd0, iord}, 32'd1);
    check("lw_memrd_reg_write", {31'd0, reg_write_en}, 32'd0);
    step("lw_memwb", 4'd4);
    check("lw_reg_write", {31'd0, reg_write_en}, 32'd1);
    check("lw_mem_to_reg", {31'd0, mem_to_reg}, 32'd1);
    check("lw_reg_dst", {31'd0, reg_dst}, 32'd0);
    step("lw_fetch", 4'd0);
    check("lw_fetch_reg_write", {31'd0, reg_write_en}, 32'd0);
    check("lw_count", instr_count, 32'd1);

    // Back-to-back R-type, then the remaining ALU functions.
    run_rtype(6'h22, 3'b110, 32'd2);
    run_rtype(6'h2A, 3'b111, 32'd3);
    run_rtype(6'h20, 3'b010, 32'd4);
    run_rtype(6'h24, 3'b000, 32'd5);
    run_rtype(6'h25, 3'b001, 32'd6);

    run_beq(1'b1, 32'd7);
    run_beq(1'b0, 32'd8);

    // addi: 0,1,9,10,0
    opcode = 6'h08;
    step("addi_decode", 4'd1);
    step("addi_exec", 4'd9);
    check("addi_alu_src_b", {30'd0, alu_src_b}, 32'd2);
    check("addi_alu_src", {31'd0, alu_src}, 32'd1);
    step("addi_wb", 4'd10);
    check("addi_reg_write", {31'd0, reg_write_en}, 32'd1);
    check("addi_reg_dst", {31'd0, reg_dst}, 32'd0);
    step("addi_fetch", 4'd0);
    check("addi_count", instr_count, 32'd9);

    // j: 0,1,11,0
    opcode = 6'h02;
    zero   = 1'b0;
    step("j_decode", 4'd1);
    step("j_jump", 4'd11);
    check("j_pc_src", {30'd0, pc_src}, 32'd2);
    check("j_pc_en", {31'd0, pc_en}, 32'd1);
    step("j_fetch", 4'd0);
    check("j_count", instr_count, 32'd10);

    // sw: 0,1,2,5,0
    opcode = 6'h2B;
    step("sw_decode", 4'd1);
    step("sw_memadr", 4'd2);
    step("sw_memwr", 4'd5);
    check("sw_mem_write", {31'd0, mem_write_en}, 32'd1);
    check("sw_iord", {31'd0, iord}, 32'd1);
    check("sw_reg_write", {31'd0, reg_write_en}, 32'd0);
    step("sw_fetch", 4'd0);
    check("sw_count", instr_count, 32'd11);

    run_illegal(6'h3F, 6'h20, 32'd11);
    run_illegal(6'h00, 6'h03, 32'd11);

    // Reset in the middle of MEMADR for a store.
    opcode = 6'h2B;
    step("rsw_decode", 4'd1);
    step("rsw_memadr", 4'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rsw_state_async", {28'd0, state}, 32'd0);
    check("rsw_count", instr_count, 32'd0);
    check("rsw_mem_write", {31'd0, mem_write_en}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rsw_hold_mem_write", {31'd0, mem_write_en}, 32'd0);
      check("rsw_hold_state", {28'd0, state}, 32'd0);
    end
    rst_n = 1'b1;
    step("rsw_after_release", 4'd1);
    check("rsw_after_count", instr_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
